ones_comp_checksum_check: RTL and testbench

- Receive-side ones'-complement checksum checker. It accumulates a frame of WIDTH-bit words, with the checksum word last, using end-around-carry addition.
- At frame end it reports pass/fail: a valid frame sums to all-ones (negative zero).
- It pairs with the existing ones'-complement subtract/complement datapath that produces the checksum on the transmit side.
- Sits between a word source (valid/ready) and status logic.

---
 rtl/ones_comp_pkg.sv | 18 +
 rtl/ones_comp_add.sv | 26 ++
 rtl/ones_comp_checksum_check.sv | 136 +++++++++++++
 tb/tb_ones_comp_checksum_check.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ones_comp_pkg.sv
// Shared types and helpers for the ones'-complement checksum blocks.
package ones_comp_pkg;

    localparam int unsigned ONES_WIDTH_DEFAULT = 4;

    typedef enum logic {
        ST_ACCUM,
        ST_CHECK
    } state_e;

    // True when the low w bits of v are all ones (ones'-complement negative zero).
    function automatic logic is_all_ones(input logic [31:0] v, input int unsigned w);
        logic [31:0] mask;
        mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return ((v & mask) == mask);
    endfunction

endpackage

// File: rtl/ones_comp_add.sv
// Combinational WIDTH-bit ones'-complement adder: full-adder ripple chain, carry-out folded back in.
module ones_comp_add
    import ones_comp_pkg::*;
#(
    parameter int unsigned WIDTH = ONES_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Y
);

    logic [WIDTH-1:0] s1;
    logic             carry;

    // The end-around increment cannot carry out again: a carry implies s1 <= 2^WIDTH-2.
    always_comb begin
        carry = 1'b0;
        s1    = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            s1[i] = A[i] ^ B[i] ^ carry;
            carry = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
        end
        Y = s1 + WIDTH'(carry);
    end

endmodule

// File: rtl/ones_comp_checksum_check.sv
// Receive-side ones'-complement checksum checker; a valid frame folds to all-ones.
// Optional macro ONES_CHK_POSZERO_EN also accepts an all-zero (positive zero) sum.
module ones_comp_checksum_check
    import ones_comp_pkg::*;
#(
    parameter  int unsigned WIDTH     = ONES_WIDTH_DEFAULT,
    parameter  int unsigned MAX_WORDS = 15,
    localparam int unsigned CW        = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic             done,
    output logic             pass,
    output logic             err_len,
    output logic [WIDTH-1:0] sum_out,
    output logic [CW-1:0]    word_cnt
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d, acc_add;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_next;
    logic             first_q, first_d;
    logic             len_err_q, len_err_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             accept, hit_max, sum_ok;

    ones_comp_add #(.WIDTH(WIDTH)) u_add (
        .A (acc_q),
        .B (data_in),
        .Y (acc_add)
    );

    assign accept = in_valid && in_ready;

    // first_q marks that the next accept opens a new frame, so the count restarts at 1.
    always_comb begin
        if (first_q) begin
            cnt_next = CW'(1);
        end else if (cnt_q == CW'(MAX_WORDS)) begin
            cnt_next = cnt_q;
        end else begin
            cnt_next = cnt_q + CW'(1);
        end
        hit_max = (cnt_next == CW'(MAX_WORDS));
    end

`ifdef ONES_CHK_POSZERO_EN
    assign sum_ok = is_all_ones(32'(acc_q), WIDTH) || (acc_q == '0);
`else
    assign sum_ok = is_all_ones(32'(acc_q), WIDTH);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCUM: if (accept && (in_last || hit_max)) state_d = ST_CHECK;
            ST_CHECK: state_d = ST_ACCUM;
            default:  state_d = ST_ACCUM;
        endcase
    end

    always_comb begin
        in_ready = (state_q == ST_ACCUM);
    end

    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        first_d   = first_q;
        len_err_d = len_err_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        err_d     = err_q;
        sum_d     = sum_q;
        if (state_q == ST_ACCUM) begin
            if (accept) begin
                acc_d     = acc_add;
                cnt_d     = cnt_next;
                first_d   = 1'b0;
                len_err_d = hit_max && !in_last;
            end
        end else begin
            sum_d     = acc_q;
            pass_d    = sum_ok && !len_err_q;
            err_d     = len_err_q;
            done_d    = 1'b1;
            acc_d     = '0;
            len_err_d = 1'b0;
            first_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            first_q   <= 1'b1;
            len_err_q <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= 1'b0;
            sum_q     <= '0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            first_q   <= first_d;
            len_err_q <= len_err_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
            sum_q     <= sum_d;
        end
    end

    assign done     = done_q;
    assign pass     = pass_q;
    assign err_len  = err_q;
    assign sum_out  = sum_q;
    assign word_cnt = cnt_q;

endmodule

// File: tb/tb_ones_comp_checksum_check.sv
// Scoreboard bench for ones_comp_checksum_check (WIDTH=4, MAX_WORDS=3) with a modular-arithmetic reference.
module tb_ones_comp_checksum_check;

    localparam int W    = 4;
    localparam int MW   = 3;
    localparam int CW   = $clog2(MW + 1);
    localparam int MAXV = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  data_in = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          in_ready, done, pass, err_len;
    logic [W-1:0]  sum_out;
    logic [CW-1:0] word_cnt;

    always #5 clk = ~clk;

    ones_comp_checksum_check #(.WIDTH(W), .MAX_WORDS(MW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .done     (done),
        .pass     (pass),
        .err_len  (err_len),
        .sum_out  (sum_out),
        .word_cnt (word_cnt)
    );

    typedef struct {
        int sum;
        bit pass;
        bit err;
        int cnt;
        int due;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   end_cyc = -10;
    int   frame_words = 0;
    int   frame_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Ones'-complement sum of a word list equals the plain integer total reduced mod 2^W-1,
    // with the residue 0 shown as all-ones unless every word was zero.
    function automatic int ref_sum(input int total);
        if (total == 0) return 0;
        return ((total - 1) % MAXV) + 1;
    endfunction

    function automatic bit ref_pass(input int s, input bit err);
`ifdef ONES_CHK_POSZERO_EN
        return !err && (s == MAXV || s == 0);
`else
        return !err && (s == MAXV);
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_reset(input int n);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst_n       = 1'b1;
        frame_words = 0;
        frame_total = 0;
        end_cyc     = -10;
    endtask

    task automatic check_cleared();
        chk("rst_done",     int'(done), 0);
        chk("rst_pass",     int'(pass), 0);
        chk("rst_err_len",  int'(err_len), 0);
        chk("rst_sum_out",  int'(sum_out), 0);
        chk("rst_word_cnt", int'(word_cnt), 0);
        chk("rst_in_ready", int'(in_ready), 1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [W-1:0] d, input bit last);
        int  waitc;
        bit  seen;
        int  s;
        exp_t e;
        waitc    = 0;
        seen     = 1'b0;
        data_in  = d;
        in_last  = last;
        in_valid = 1'b1;
        while (!seen) begin
            @(negedge clk);
            if (in_ready) begin
                seen = 1'b1;
            end else begin
                waitc++;
                if (waitc > 20) begin
                    chk("ready_timeout", 0, 1);
                    return;
                end
            end
        end
        @(posedge clk);
        #1;
        frame_words++;
        frame_total += int'(d);
        chk("word_cnt", int'(word_cnt), frame_words);
        chk("acc", int'(dut.acc_q), ref_sum(frame_total));
        if (last || frame_words == MW) begin
            s      = ref_sum(frame_total);
            e.sum  = s;
            e.err  = !last;
            e.pass = ref_pass(s, !last);
            e.cnt  = frame_words;
            e.due  = cyc + 1;
            sbq.push_back(e);
            end_cyc     = cyc;
            frame_words = 0;
            frame_total = 0;
        end
    endtask

    // Monitor: in_ready low only in the cycle right after a frame-ending accept; results on done.
    always @(negedge clk) begin
        if (rst_n && cyc > 0) begin
            chk("in_ready", int'(in_ready), (cyc != end_cyc) ? 1 : 0);
            if (done) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("done_cycle", cyc, e.due);
                    chk("sum_out",  int'(sum_out), e.sum);
                    chk("pass",     int'(pass), int'(e.pass));
                    chk("err_len",  int'(err_len), int'(e.err));
                    chk("done_cnt", int'(word_cnt), e.cnt);
                end
            end else if (sbq.size() > 0 && cyc >= sbq[0].due) begin
                chk("done_missing", 0, 1);
                void'(sbq.pop_front());
            end
        end
    end

    initial begin
        int n;
        int tot;
        bit good;
        logic [W-1:0] w;

        do_reset(3);
        check_cleared();

        // Good frame, then the same frame with a corrupted checksum.
        send(4'b0101, 0); send(4'b0011, 0); send(4'b0111, 1); idle(3);
        send(4'b0101, 0); send(4'b0011, 0); send(4'b0110, 1); idle(3);

        // End-around carry on the second word.
        send(4'b1100, 0); send(4'b0110, 0); send(4'b1100, 1); idle(3);

        // Valid held high across back-to-back frames.
        send(4'b0101, 0); send(4'b0011, 0); send(4'b0111, 1); send(4'b1111, 1); idle(3);

        // Length error at MAX_WORDS; the next word opens a new frame.
        send(4'b0001, 0); send(4'b0010, 0); send(4'b0100, 0);
        send(4'b1000, 0); send(4'b0110, 1); idle(3);

        // Last word on the MAX_WORDS-th word is a normal end.
        send(4'b0001, 0); send(4'b0010, 0); send(4'b1100, 1); idle(3);

        // Mid-frame reset discards the partial frame.
        send(4'b0001, 0); send(4'b0010, 0);
        do_reset(1);
        check_cleared();
        idle(4);
        send(4'b0000, 0); send(4'b1111, 1); idle(3);
        send(4'b0000, 1); idle(3);

        // Randomized frames, some with a correct checksum, some overrunning MAX_WORDS.
        for (int f = 0; f < 60; f++) begin
            n    = int'($urandom_range(1, MW + 1));
            good = 1'($urandom_range(0, 1));
            tot  = 0;
            if (n > MW) begin
                for (int i = 0; i < MW; i++) begin
                    w = W'($urandom);
                    send(w, 0);
                    if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
                end
            end else begin
                for (int i = 0; i < n; i++) begin
                    w = W'($urandom);
                    if (i == n - 1 && good) w = W'(~ref_sum(tot));
                    tot += int'(w);
                    send(w, (i == n - 1));
                    if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
                end
            end
        end
        idle(5);
        chk("queue_empty", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
